data_ip_axil_regs: RTL
======================

// Module: data_ip_axil_regs
// PURPOSE
//  AXI4-Lite slave register bank behind the data_ip master VIP port: four 32-bit RW registers at 0x0/0x4/0x8/0xC.
//  Terminates the AXI4-Lite write/read channels and drives register contents plus per-register write strobes
//  to the data path downstream. One write and one read outstanding at a time; write and read paths independent.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  data width; only 32 supported
//  C_S_AXI_ADDR_WIDTH  4   address width (>=4); bits [1:0] ignored, [3:2] select register
// PORTS
//  ACLK            in   1    clock, all logic on rising edge
//  ARESET          in   1    synchronous, active-high reset
//  S_AXI_AWADDR    in   AW   write address
//  S_AXI_AWPROT    in   3    ignored
//  S_AXI_AWVALID   in   1    write address valid
//  S_AXI_AWREADY   out  1    write address ready
//  S_AXI_WDATA     in   32   write data
//  S_AXI_WSTRB     in   4    byte enables
//  S_AXI_WVALID    in   1    write data valid
//  S_AXI_WREADY    out  1    write data ready
//  S_AXI_BRESP     out  2    write response
//  S_AXI_BVALID    out  1    write response valid
//  S_AXI_BREADY    in   1    write response ready
//  S_AXI_ARADDR    in   AW   read address
//  S_AXI_ARPROT    in   3    ignored
//  S_AXI_ARVALID   in   1    read address valid
//  S_AXI_ARREADY   out  1    read address ready
//  S_AXI_RDATA     out  32   read data
//  S_AXI_RRESP     out  2    read response
//  S_AXI_RVALID    out  1    read data valid
//  S_AXI_RREADY    in   1    read data ready
//  REG_OUT         out  128  {reg3,reg2,reg1,reg0}, live register contents
//  REG_WR_STB      out  4    one-hot, 1-cycle pulse on cycle a register is committed
// BEHAVIOUR
//  Reset (ARESET=1 at edge): reg0..3=0, all READY/VALID=0, BRESP/RRESP=0, RDATA=0, REG_WR_STB=0, holders empty.
//  Write FSM: W_IDLE -> (AW and W both held) W_COMMIT -> W_RESP -> W_IDLE.
//   - AW and W accepted independently into one-deep holders; AWREADY=1 iff AW holder empty and state W_IDLE;
//     same for WREADY. Either order, or both same cycle, accepted.
//   - Both accepted by edge N: register updated and REG_WR_STB pulsed during N+1 (W_COMMIT); BVALID=1 from N+2.
//   - Byte lane k written only if WSTRB[k]; WSTRB=0 commits nothing but still responds OKAY and pulses strobe.
//   - BVALID held, BRESP stable, until BREADY; then holders clear, back to W_IDLE next cycle.
//  Read FSM: R_IDLE -> R_DATA -> R_IDLE.
//   - ARREADY=1 in R_IDLE with RVALID=0. AR accepted at edge N: RDATA/RRESP registered at that edge, RVALID=1 at N+1.
//   - RDATA/RRESP held stable until RREADY; RVALID drops the cycle after handshake; ARREADY returns then.
//  Decode: ADDR bits above [3:2] nonzero (only if AW>4) -> SLVERR(2'b10), no write, no strobe, RDATA=0.
//   In-range -> OKAY(2'b00).
//  Simultaneous read and write commit to same register on one edge: read returns pre-write value.
//  Back-to-back: new AW/W may be held while BVALID pending only after B handshake (no overlap).
//  Reset mid-transaction: all in-flight transfers dropped, no B/R issued, registers cleared.
//  REG_OUT reflects register state combinationally from flops (no extra latency).
// TESTING
//  Reset, then AW=0x0/W=0x00000001/WSTRB=F same cycle -> REG_WR_STB=0001 one cycle, BVALID 2 cycles later, BRESP=0.
//  Write 1..4 to 0x0,0x4,0x8,0xC then read back in order -> RDATA 1,2,3,4, RRESP=0; REG_OUT=0x00000004_00000003_00000002_00000001.
//  W presented 3 cycles before AW to 0x8 -> WREADY low after capture, commit only after AW; reg2 updated once.
//  reg1=0xAABBCCDD, write 0x11223344 WSTRB=0101 -> reg1=0xAA22CC44.
//  BREADY/RREADY held low 5 cycles -> BVALID/RVALID, BRESP/RDATA stable; AWREADY/ARREADY stay 0 throughout.
//  ARESET asserted with BVALID pending -> next cycle BVALID=0, reg0..3=0, new write completes normally.

Source files
------------

// File: rtl/data_ip_axil_regs.sv
// ============================================================================
// data_ip_axil_regs
// ----------------------------------------------------------------------------
// AXI4-Lite slave register bank with four 32-bit read/write registers at byte
// offsets 0x0, 0x4, 0x8 and 0xC. It terminates the write and read channels and
// exports the live register contents plus a one-hot commit strobe to the data
// path downstream. One write and one read may be outstanding at a time, and the
// write and read paths run independently of each other.
//
// Ports
//   ACLK, ARESET        clock (rising edge); synchronous active-high reset
//   S_AXI_AW*           write address channel (AWPROT ignored)
//   S_AXI_W*            write data channel, WSTRB gives the byte enables
//   S_AXI_B*            write response channel
//   S_AXI_AR*           read address channel (ARPROT ignored)
//   S_AXI_R*            read data channel
//   REG_OUT             {reg3, reg2, reg1, reg0}, driven directly from the flops
//   REG_WR_STB          one-hot, high for the single cycle a register commits
//
// Address decode: bits [3:2] select the register and bits [1:0] are ignored.
// Any nonzero address bit above bit 3 returns SLVERR. Such a write changes no
// register and raises no strobe. Such a read returns zero data.
// ============================================================================
module data_ip_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0]   REG_OUT,
    output logic [3:0]                        REG_WR_STB
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int SW = DW / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}           r_state_t;

    w_state_t          w_state_reg;
    r_state_t          r_state_reg;

    // Holds the READY outputs low while reset is asserted and for one cycle after it.
    logic              rdy_en_reg;

    // One-deep holders for the write address and write data.
    logic              aw_full_reg;
    logic              w_full_reg;
    logic [AW-1:0]     awaddr_reg;
    logic [DW-1:0]     wdata_reg;
    logic [SW-1:0]     wstrb_reg;

    logic              bvalid_reg;
    logic [1:0]        bresp_reg;
    logic              rvalid_reg;
    logic [1:0]        rresp_reg;
    logic [DW-1:0]     rdata_reg;

    logic              aw_hs;
    logic              w_hs;
    logic              ar_hs;
    logic              aw_err;
    logic              ar_err;
    logic [3:0]        wr_sel;
    logic [DW-1:0]     rd_word;
    logic [4*DW-1:0]   reg_out_w;

    // ------------------------------------------------------------------------
    // Handshake qualifiers. The READY signals depend only on flops.
    // ------------------------------------------------------------------------
    assign S_AXI_AWREADY = rdy_en_reg && !aw_full_reg && (w_state_reg == W_IDLE);
    assign S_AXI_WREADY  = rdy_en_reg && !w_full_reg  && (w_state_reg == W_IDLE);
    assign S_AXI_ARREADY = rdy_en_reg && !rvalid_reg  && (r_state_reg == R_IDLE);

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // ------------------------------------------------------------------------
    // Out-of-range decode. This only applies when the address bus is wider
    // than the 16-byte window.
    // ------------------------------------------------------------------------
    generate
        if (AW > 4) begin : g_hi_decode
            assign aw_err = |awaddr_reg[AW-1:4];
            assign ar_err = |S_AXI_ARADDR[AW-1:4];
        end else begin : g_no_hi_decode
            assign aw_err = 1'b0;
            assign ar_err = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Register bank. A register commits on the edge that ends W_COMMIT.
    // REG_WR_STB marks that cycle.
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_reg
            logic [DW-1:0] data_reg;

            assign wr_sel[gi] = (w_state_reg == W_COMMIT) && !aw_err &&
                                (awaddr_reg[3:2] == 2'(gi));

            always_ff @(posedge ACLK) begin
                if (ARESET) begin
                    data_reg <= '0;
                end else if (wr_sel[gi]) begin
                    for (int b = 0; b < SW; b++) begin
                        if (wstrb_reg[b]) begin
                            data_reg[8*b +: 8] <= wdata_reg[8*b +: 8];
                        end
                    end
                end
            end

            assign reg_out_w[gi*DW +: DW] = data_reg;
        end
    endgenerate

    assign REG_OUT    = reg_out_w;
    assign REG_WR_STB = wr_sel;

    // Read mux. It uses the register state before any commit on the same edge.
    assign rd_word = reg_out_w[DW*int'(S_AXI_ARADDR[3:2]) +: DW];

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rdy_en_reg <= 1'b0;
        end else begin
            rdy_en_reg <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_reg <= W_IDLE;
            aw_full_reg <= 1'b0;
            w_full_reg  <= 1'b0;
            awaddr_reg  <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_full_reg <= 1'b1;
                        awaddr_reg  <= S_AXI_AWADDR;
                    end
                    if (w_hs) begin
                        w_full_reg <= 1'b1;
                        wdata_reg  <= S_AXI_WDATA;
                        wstrb_reg  <= S_AXI_WSTRB;
                    end
                    if ((aw_full_reg || aw_hs) && (w_full_reg || w_hs)) begin
                        w_state_reg <= W_COMMIT;
                    end
                end
                W_COMMIT: begin
                    bvalid_reg  <= 1'b1;
                    bresp_reg   <= aw_err ? RESP_SLVERR : RESP_OKAY;
                    w_state_reg <= W_RESP;
                end
                W_RESP: begin
                    // The holders stay full until the response is taken. This
                    // keeps AW/W from being accepted while BVALID is pending.
                    if (S_AXI_BREADY) begin
                        bvalid_reg  <= 1'b0;
                        aw_full_reg <= 1'b0;
                        w_full_reg  <= 1'b0;
                        w_state_reg <= W_IDLE;
                    end
                end
                default: begin
                    w_state_reg <= W_IDLE;
                end
            endcase
        end
    end

    assign S_AXI_BVALID = bvalid_reg;
    assign S_AXI_BRESP  = bresp_reg;

    // ------------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state_reg <= R_IDLE;
            rvalid_reg  <= 1'b0;
            rresp_reg   <= RESP_OKAY;
            rdata_reg   <= '0;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (ar_hs) begin
                        rdata_reg   <= ar_err ? '0 : rd_word;
                        rresp_reg   <= ar_err ? RESP_SLVERR : RESP_OKAY;
                        rvalid_reg  <= 1'b1;
                        r_state_reg <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        rvalid_reg  <= 1'b0;
                        r_state_reg <= R_IDLE;
                    end
                end
                default: begin
                    r_state_reg <= R_IDLE;
                end
            endcase
        end
    end

    assign S_AXI_RVALID = rvalid_reg;
    assign S_AXI_RRESP  = rresp_reg;
    assign S_AXI_RDATA  = rdata_reg;

    // Protection bits and the byte-offset address bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_ARADDR[1:0], awaddr_reg[1:0]};

endmodule
